inst_fetch_unit: RTL and testbench

Instruction fetch stage that is the reader side of the single-cycle instruction ROM. It owns the program counter and drives the word-aligned fetch address. It captures the returned instruction into an output register and hands it to decode with a valid/ready handshake. It also applies branch and jump redirects, flushing the in-flight instruction, and halts on an out-of-range fetch address.

---
 rtl/inst_fetch_unit_pkg.sv | 25 ++
 rtl/inst_fetch_unit_fetch_target_calc.sv | 26 ++
 rtl/inst_fetch_unit.sv | 118 +++++++++++
 tb/tb_inst_fetch_unit.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_unit_pkg.sv
// Shared fetch/decode definitions: fetch FSM encoding, instruction width,
// MIPS opcode constants and the branch offset helper.
package inst_fetch_unit_pkg;

  localparam int INST_W = 32;

  typedef enum logic [1:0] {
    FETCH_BOOT = 2'd0,
    FETCH_RUN  = 2'd1,
    FETCH_HALT = 2'd2
  } fetch_state_t;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;

  // Signed word offset scaled to a byte offset.
  function automatic logic [31:0] word_offset(input logic [15:0] off);
    return {{14{off[15]}}, off, 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch_unit_fetch_target_calc.sv
// Combinational redirect target: branch and jump targets, branch wins when
// both are requested since it is the older instruction.
module fetch_target_calc
  import inst_fetch_unit_pkg::*;
(
  input  logic        br_valid,
  input  logic [31:0] br_pc,
  input  logic [15:0] br_offset,
  input  logic        jmp_valid,
  input  logic [31:0] jmp_pc,
  input  logic [25:0] jmp_index,
  output logic        redirect,
  output logic [31:0] target
);

  logic [31:0] br_target;
  logic [31:0] jmp_target;

  always_comb begin
    br_target  = br_pc + 32'd4 + word_offset(br_offset);
    jmp_target = ((jmp_pc + 32'd4) & 32'hF000_0000) | {4'b0000, jmp_index, 2'b00};
    redirect   = br_valid | jmp_valid;
    target     = br_valid ? br_target : jmp_target;
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads the single-cycle ROM, registers
// the instruction for decode, applies redirects and halts on a bad address.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ROM_AW   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [31:0]       addr,
  input  logic [INST_W-1:0] inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [31:0]       out_pc,
  input  logic              br_valid,
  input  logic [31:0]       br_pc,
  input  logic [15:0]       br_offset,
  input  logic              jmp_valid,
  input  logic [31:0]       jmp_pc,
  input  logic [25:0]       jmp_index,
  output logic              halted,
  output logic [31:0]       fetch_count,
  output fetch_state_t      state
);

  // Handshake: decode takes out_inst/out_pc in any cycle where out_valid and
  // out_ready are both high; out_valid never depends on out_ready in the same
  // cycle, and a redirect in that cycle cancels the transfer.

  fetch_state_t      state_q, state_d;
  logic [31:0]       pc_q;
  logic              out_valid_q;
  logic [INST_W-1:0] out_inst_q;
  logic [31:0]       out_pc_q;
  logic [31:0]       fetch_count_q;

  logic        redirect;
  logic [31:0] target;
  logic        addr_err;
  logic        take_redirect;
  logic        load;
  logic        go_halt;
  logic        accept;

  fetch_target_calc u_target_calc (
    .br_valid  (br_valid),
    .br_pc     (br_pc),
    .br_offset (br_offset),
    .jmp_valid (jmp_valid),
    .jmp_pc    (jmp_pc),
    .jmp_index (jmp_index),
    .redirect  (redirect),
    .target    (target)
  );

  assign addr_err = ((pc_q >> (ROM_AW + 2)) != 32'd0) || (pc_q[1:0] != 2'b00);

  always_comb begin
    state_d       = state_q;
    take_redirect = 1'b0;
    load          = 1'b0;
    go_halt       = 1'b0;
    accept        = 1'b0;
    case (state_q)
      FETCH_BOOT: state_d = FETCH_RUN;
      FETCH_RUN: begin
        take_redirect = redirect;
        accept        = out_valid_q & out_ready & ~redirect;
        // A redirect suppresses the address check; the new PC is checked next cycle.
        if (!redirect && (!out_valid_q || out_ready)) begin
          if (addr_err) begin
            go_halt = 1'b1;
            state_d = FETCH_HALT;
          end else begin
            load = 1'b1;
          end
        end
      end
      default: state_d = FETCH_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FETCH_BOOT;
      pc_q          <= RESET_PC;
      out_valid_q   <= 1'b0;
      out_inst_q    <= '0;
      out_pc_q      <= '0;
      fetch_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (take_redirect) begin
        pc_q        <= target;
        out_valid_q <= 1'b0;
      end else if (load) begin
        pc_q        <= pc_q + 32'd4;
        out_valid_q <= 1'b1;
        out_inst_q  <= inst;
        out_pc_q    <= pc_q;
      end else if (go_halt) begin
        out_valid_q <= 1'b0;
      end
      if (accept) fetch_count_q <= fetch_count_q + 32'd1;
    end
  end

  assign addr        = pc_q;
  assign out_valid   = out_valid_q;
  assign out_inst    = out_inst_q;
  assign out_pc      = out_pc_q;
  assign fetch_count = fetch_count_q;
  assign halted      = (state_q == FETCH_HALT);
  assign state       = state_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed walk through fetch, stall, redirect and
// halt, then randomized traffic against a behavioural model of the fetch rules.
module tb_inst_fetch_unit;
  import inst_fetch_unit_pkg::*;

  localparam int          ROM_AW   = 8;
  localparam int          ROM_WORDS = 1 << ROM_AW;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0]  addr;
  logic [31:0]  inst;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_inst;
  logic [31:0]  out_pc;
  logic         br_valid;
  logic [31:0]  br_pc;
  logic [15:0]  br_offset;
  logic         jmp_valid;
  logic [31:0]  jmp_pc;
  logic [25:0]  jmp_index;
  logic         halted;
  logic [31:0]  fetch_count;
  fetch_state_t state;

  logic [31:0] rom [ROM_WORDS];
  assign inst = (addr < 32'(ROM_WORDS * 4)) ? rom[addr[ROM_AW+1:2]] : 32'hDEAD_BEEF;

  inst_fetch_unit #(.RESET_PC(RESET_PC), .ROM_AW(ROM_AW)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .inst(inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .br_valid(br_valid), .br_pc(br_pc), .br_offset(br_offset),
    .jmp_valid(jmp_valid), .jmp_pc(jmp_pc), .jmp_index(jmp_index),
    .halted(halted), .fetch_count(fetch_count), .state(state)
  );

  // scoreboard counters
  int checks = 0;
  int passes = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // behavioural model
  logic [31:0] m_pc, m_oi, m_opc, m_cnt;
  logic        m_ov, m_halt, m_boot;

  function automatic logic [31:0] model_br_target(input logic [31:0] pc, input logic [15:0] off);
    logic [31:0] soff;
    soff = {{16{off[15]}}, off};
    return pc + 32'd4 + soff * 32'd4;
  endfunction

  function automatic logic [31:0] model_jmp_target(input logic [31:0] pc, input logic [25:0] idx);
    logic [31:0] p4;
    p4 = pc + 32'd4;
    return (p4 & 32'hF000_0000) + (32'(idx) * 32'd4);
  endfunction

  function automatic bit model_bad_addr(input logic [31:0] pc);
    return (pc >= 32'(ROM_WORDS * 4)) || (pc % 4 != 0);
  endfunction

  task automatic model_reset();
    m_pc = RESET_PC; m_ov = 1'b0; m_oi = '0; m_opc = '0;
    m_cnt = '0; m_halt = 1'b0; m_boot = 1'b1;
  endtask

  task automatic model_clock();
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (!m_halt) begin
      if (br_valid || jmp_valid) begin
        m_pc = br_valid ? model_br_target(br_pc, br_offset) : model_jmp_target(jmp_pc, jmp_index);
        m_ov = 1'b0;
      end else if (!m_ov || out_ready) begin
        if (m_ov && out_ready) m_cnt = m_cnt + 1;
        if (model_bad_addr(m_pc)) begin
          m_ov = 1'b0;
          m_halt = 1'b1;
        end else begin
          m_oi = rom[m_pc[ROM_AW+1:2]];
          m_opc = m_pc;
          m_ov = 1'b1;
          m_pc = m_pc + 32'd4;
        end
      end
    end
  endtask

  task automatic check_all();
    check("addr", addr, m_pc);
    check("out_valid", 32'(out_valid), 32'(m_ov));
    check("out_inst", out_inst, m_oi);
    check("out_pc", out_pc, m_opc);
    check("halted", 32'(halted), 32'(m_halt));
    check("fetch_count", fetch_count, m_cnt);
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic clear_redirects();
    br_valid = 1'b0; jmp_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < ROM_WORDS; i++) rom[i] = $urandom;
    out_ready = 1'b1;
    br_pc = '0; br_offset = '0; jmp_pc = '0; jmp_index = '0;
    clear_redirects();

    // sequential fetch from reset
    do_reset();
    check("boot_addr", addr, 32'h0);
    step();
    step();
    check("first_out_pc", out_pc, 32'h0);
    check("first_out_valid", 32'(out_valid), 32'd1);
    step();
    step();

    // stall with a valid word held at 0x8
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("stall_addr", addr, 32'hC);
    check("stall_out_pc", out_pc, 32'h8);
    check("stall_count", fetch_count, 32'd2);
    out_ready = 1'b1;
    step();
    check("count_after_3", fetch_count, 32'd3);

    // forward branch
    br_valid = 1'b1; br_pc = 32'h34; br_offset = 16'h0003;
    step();
    check("br_addr", addr, 32'h44);
    check("br_bubble", 32'(out_valid), 32'd0);
    clear_redirects();
    step();
    check("br_out_pc", out_pc, 32'h44);

    // backward branch racing a jump
    br_valid = 1'b1; br_pc = 32'h10; br_offset = 16'hFFFE;
    jmp_valid = 1'b1; jmp_pc = 32'h4C; jmp_index = 26'h000000F;
    step();
    check("br_prio_addr", addr, 32'h0C);
    clear_redirects();
    step();

    // jump then continuous fetch
    jmp_valid = 1'b1; jmp_pc = 32'h4C; jmp_index = 26'h000000F;
    step();
    check("jmp_addr", addr, 32'h3C);
    clear_redirects();
    step();
    check("jmp_out_pc", out_pc, 32'h3C);
    step();
    check("jmp_next_pc", out_pc, 32'h40);

    // jump out of the ROM then halt
    jmp_valid = 1'b1; jmp_index = 26'h0000100;
    step();
    check("oob_addr", addr, 32'h400);
    clear_redirects();
    step();
    check("halt_set", 32'(halted), 32'd1);
    br_valid = 1'b1; br_pc = 32'h0; br_offset = 16'h0;
    step();
    check("halt_ignores_br", addr, 32'h400);
    clear_redirects();
    step();
    do_reset();
    check("reset_clears_halt", 32'(halted), 32'd0);
    check("reset_pc", addr, RESET_PC);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      br_valid  = ($urandom_range(0, 15) == 0);
      br_pc     = 32'($urandom_range(0, ROM_WORDS - 1)) * 32'd4
                  + (($urandom_range(0, 31) == 0) ? 32'd1 : 32'd0);
      br_offset = 16'($urandom_range(0, 40)) - 16'd20;
      jmp_valid = ($urandom_range(0, 15) == 0);
      jmp_pc    = 32'($urandom_range(0, ROM_WORDS - 1)) * 32'd4;
      jmp_index = ($urandom_range(0, 7) == 0) ? 26'($urandom_range(0, 4 * ROM_WORDS - 1))
                                              : 26'($urandom_range(0, ROM_WORDS - 1));
      if ((m_halt && $urandom_range(0, 7) == 0) || $urandom_range(0, 399) == 0) do_reset();
      step();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
